// File: rtl/cpu_pkg.sv
// Shared encodings for the cpu core: opcodes, ALU ops, shift codes,
// controller states and datapath select codes.
package cpu_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE
  } state_e;

  typedef enum logic [1:0] {
    NSEL_RN,
    NSEL_RD,
    NSEL_RM
  } nsel_e;

  typedef enum logic {
    VSEL_C,
    VSEL_IMM
  } vsel_e;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_datapath.sv
// Register file, shifter, ALU, A/B/C latches and N/V/Z status.
// CPU_ASR_EN selects arithmetic (vs logical) right shift for sh=11.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [2:0]  regnum,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);

  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];

  always_comb begin
    regs_d = regs_q;
    if (write) regs_d[regnum] = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata = regs_q[regnum];

endmodule

module cpu_datapath
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  regnum,
  input  logic        write,
  input  vsel_e       vsel,
  input  logic [15:0] sximm8,
  input  logic        loada,
  input  logic        loadb,
  input  logic        loadc,
  input  logic        loads,
  input  logic        asel,
  input  logic [1:0]  sh,
  input  logic [1:0]  alu_op,
  output logic [15:0] c_out,
  output logic        n_out,
  output logic        v_out,
  output logic        z_out
);

  logic [15:0] rdata;
  logic [15:0] wdata;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] c_q, c_d;
  logic        n_q, n_d;
  logic        v_q, v_d;
  logic        z_q, z_d;
  logic [15:0] a_op;
  logic [15:0] b_sh;
  logic [15:0] alu_out;
  logic        ovf;

  assign wdata = (vsel == VSEL_IMM) ? sximm8 : c_q;

  cpu_regfile REGFILE (
    .clk    (clk),
    .reset  (reset),
    .write  (write),
    .regnum (regnum),
    .wdata  (wdata),
    .rdata  (rdata)
  );

  always_comb begin
    b_sh = b_q;
    unique case (sh)
      SH_NONE: b_sh = b_q;
      SH_LSL:  b_sh = {b_q[14:0], 1'b0};
      SH_LSR:  b_sh = {1'b0, b_q[15:1]};
      SH_ASR:
`ifdef CPU_ASR_EN
        b_sh = {b_q[15], b_q[15:1]};
`else
        b_sh = {1'b0, b_q[15:1]};
`endif
    endcase
  end

  assign a_op = asel ? 16'h0000 : a_q;

  always_comb begin
    alu_out = '0;
    unique case (alu_op)
      OP_ADD: alu_out = a_op + b_sh;
      OP_CMP: alu_out = a_op - b_sh;
      OP_AND: alu_out = a_op & b_sh;
      OP_MVN: alu_out = ~b_sh;
    endcase
  end

  // Subtraction overflows when operand signs differ and result sign flips.
  assign ovf = (a_op[15] != b_sh[15]) && (alu_out[15] != a_op[15]);

  always_comb begin
    a_d = loada ? rdata : a_q;
    b_d = loadb ? rdata : b_q;
    c_d = loadc ? alu_out : c_q;
    n_d = loads ? alu_out[15] : n_q;
    v_d = loads ? ovf : v_q;
    z_d = loads ? (alu_out == 16'h0000) : z_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      n_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      n_q <= n_d;
      v_q <= v_d;
      z_q <= z_d;
    end
  end

  assign c_out = c_q;
  assign n_out = n_q;
  assign v_out = v_q;
  assign z_out = z_q;

endmodule

// File: rtl/cpu.sv
// Multi-cycle 16-bit core: instruction register, decoder and controller.
// Optional macro CPU_ASR_EN enables arithmetic shift right (see datapath).
module cpu
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        N,
  output logic        V,
  output logic        Z,
  output logic        w
);

  logic [15:0] ir_q, ir_d;
  state_e      state_q, state_d;
  logic        w_q;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;
  logic [15:0] sximm8;

  logic is_movi, is_movr, is_mvn, is_alu3, is_cmp;

  nsel_e      nsel;
  vsel_e      vsel;
  logic [2:0] regnum;
  logic       write, loada, loadb, loadc, loads, asel;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];
  assign sximm8 = sext8(ir_q[7:0]);

  assign is_movi = (opcode == OPC_MOV) && (op == OP_MOVI);
  assign is_movr = (opcode == OPC_MOV) && (op == OP_MOVR);
  assign is_mvn  = (opcode == OPC_ALU) && (op == OP_MVN);
  assign is_alu3 = (opcode == OPC_ALU) && (op != OP_MVN);
  assign is_cmp  = (opcode == OPC_ALU) && (op == OP_CMP);

  assign ir_d = load ? in : ir_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:      if (s) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_movi:           state_d = S_WRITE_IMM;
          (is_movr||is_mvn): state_d = S_GET_B;
          is_alu3:           state_d = S_GET_A;
          default:           state_d = S_WAIT;
        endcase
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_EXEC;
      S_EXEC:      state_d = is_cmp ? S_WAIT : S_WRITE;
      S_WRITE:     state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      w_q     <= 1'b1;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= (state_d == S_WAIT);
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    nsel  = NSEL_RN;
    vsel  = VSEL_C;
    write = 1'b0;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    case (state_q)
      S_WRITE_IMM: begin
        write = 1'b1;
        vsel  = VSEL_IMM;
      end
      S_GET_A: loada = 1'b1;
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_EXEC: begin
        loadc = 1'b1;
        loads = is_cmp;
      end
      S_WRITE: begin
        nsel  = NSEL_RD;
        write = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    regnum = rn;
    case (nsel)
      NSEL_RD: regnum = rd;
      NSEL_RM: regnum = rm;
      default: regnum = rn;
    endcase
  end

  // MOV reg goes through the adder with a zero A operand.
  assign asel = (opcode == OPC_MOV);

  cpu_datapath DP (
    .clk    (clk),
    .reset  (reset),
    .regnum (regnum),
    .write  (write),
    .vsel   (vsel),
    .sximm8 (sximm8),
    .loada  (loada),
    .loadb  (loadb),
    .loadc  (loadc),
    .loads  (loads),
    .asel   (asel),
    .sh     (sh),
    .alu_op (op),
    .c_out  (out),
    .n_out  (N),
    .v_out  (V),
    .z_out  (Z)
  );

  assign w = w_q;

endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for the cpu core.
// Expected values are hand-computed from the instruction semantics.
module tb_cpu;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic        s;
  logic        load;
  logic [15:0] in_i;
  logic [15:0] out;
  logic        N, V, Z, w;

  int errs;
  int checks;
  int lat;

  cpu dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .load  (load),
    .in    (in_i),
    .out   (out),
    .N     (N),
    .V     (V),
    .Z     (Z),
    .w     (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] R(input int i);
    return dut.DP.REGFILE.regs_q[i];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [15:0] instr, output int cyc);
    @(negedge clk);
    in_i = instr;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    s = 1'b1;
    @(negedge clk);
    s = 1'b0;
    cyc = 1;
    while (w !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("w_return", {15'd0, w}, 16'd1);
  endtask

  initial begin
    errs = 0;
    checks = 0;
    reset = 1'b1;
    s = 1'b0;
    load = 1'b0;
    in_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_w", {15'd0, w}, 16'd1);
    chk("rst_out", out, 16'h0000);
    chk("rst_nvz", {13'd0, N, V, Z}, 16'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_R%0d", i), R(i), 16'h0);
    reset = 1'b0;

    run(16'hD007, lat);
    chk("movi_R0", R(0), 16'h0007);
    chk("movi_lat", 16'(lat), 16'd3);
    run(16'hD1FF, lat);
    chk("movi_neg_R1", R(1), 16'hFFFF);

    run(16'hD101, lat);
    run(16'hC049, lat);
    chk("lsl_R2", R(2), 16'h0002);
    chk("movr_lat", 16'(lat), 16'd5);
    run(16'hC052, lat);
    chk("lsr_R2", R(2), 16'h0001);

    run(16'hD280, lat);
    for (int i = 0; i < 8; i++) run(16'hC04A, lat);
    chk("R2_8000", R(2), 16'h8000);
    run(16'hC05A, lat);
`ifdef CPU_ASR_EN
    chk("sh11_R2", R(2), 16'hC000);
`else
    chk("sh11_R2", R(2), 16'h4000);
`endif

    run(16'hD204, lat);
    run(16'hD301, lat);
    run(16'hA223, lat);
    chk("add_R1", R(1), 16'h0005);
    chk("add_out", out, 16'h0005);
    chk("add_lat", 16'(lat), 16'd6);
    run(16'hD2FF, lat);
    run(16'hA223, lat);
    chk("add_wrap_R1", R(1), 16'h0000);

    run(16'hD005, lat);
    run(16'hD105, lat);
    run(16'hA801, lat);
    chk("cmp_eq_nvz", {13'd0, N, V, Z}, 16'b001);
    chk("cmp_lat", 16'(lat), 16'd5);
    chk("cmp_R0", R(0), 16'h0005);
    chk("cmp_R1", R(1), 16'h0005);

    run(16'hD080, lat);
    for (int i = 0; i < 8; i++) run(16'hC008, lat);
    run(16'hD101, lat);
    chk("R0_8000", R(0), 16'h8000);
    run(16'hA801, lat);
    chk("cmp_ovf_nvz", {13'd0, N, V, Z}, 16'b010);
    chk("cmp2_R0", R(0), 16'h8000);
    chk("cmp2_R1", R(1), 16'h0001);

    run(16'hD206, lat);
    run(16'hD103, lat);
    run(16'hB281, lat);
    chk("and_R4", R(4), 16'h0002);
    chk("and_lat", 16'(lat), 16'd6);
    chk("and_nvz", {13'd0, N, V, Z}, 16'b010);

    run(16'hD007, lat);
    run(16'hB8A0, lat);
    chk("mvn_R5", R(5), 16'hFFF8);
    chk("mvn_out", out, 16'hFFF8);
    chk("mvn_lat", 16'(lat), 16'd5);
    chk("mvn_nvz", {13'd0, N, V, Z}, 16'b010);

    run(16'h0000, lat);
    chk("undef_lat", 16'(lat), 16'd2);
    chk("undef_R5", R(5), 16'hFFF8);
    chk("undef_out", out, 16'hFFF8);

    run(16'hD209, lat);
    run(16'hD301, lat);
    @(negedge clk);
    in_i = 16'hA223;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    s = 1'b1;
    @(negedge clk);
    s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_state", 16'(dut.state_q), 16'(S_GET_B));
    chk("mid_w", {15'd0, w}, 16'd0);
    #1 reset = 1'b1;
    #1;
    chk("arst_w", {15'd0, w}, 16'd1);
    chk("arst_out", out, 16'h0000);
    for (int i = 0; i < 8; i++) chk($sformatf("arst_R%0d", i), R(i), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_w", {15'd0, w}, 16'd1);
    chk("post_R1", R(1), 16'h0000);
    chk("post_nvz", {13'd0, N, V, Z}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Multi-cycle 16-bit processor core with an eight-entry register file (R0–R7), one instruction register, and A/B/C pipeline latches.
- Shifter, ALU and a 3-bit status register (N, V, Z).
- Executes one instruction per start pulse under a small controller FSM.
- `w` signals idle/ready to the enclosing system.

Parameters:
- None. Data width is fixed at 16 bits and the register count at 8.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- s  in  1  start; sampled only in WAIT
- load  in  1  instruction-register load enable
- in  in  16  instruction word
- out  out  16  contents of register C (datapath output)
- N  out  1  status negative
- V  out  1  status signed overflow
- Z  out  1  status zero
- w  out  1  high only in WAIT state

Behaviour:
- Reset (async): FSM→WAIT; IR, A, B, C, N, V, Z, R0–R7 cleared; out=0, w=1.
- IR loads `in` on any rising edge with load=1, independent of FSM state.
- Decode fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0], im8=IR[7:0] sign-extended to 16 bits.
- Instructions:
  - 110/10 MOV Rn,#im8
  - 110/00 MOV Rd,Rm{sh}
  - 101/00 ADD Rd,Rn,Rm{sh}
  - 101/01 CMP Rn,Rm{sh}
  - 101/10 AND Rd,Rn,Rm{sh}
  - 101/11 MVN Rd,Rm{sh}
- Shift on B operand: 00 none, 01 LSL by 1 (zero in), 10 LSR by 1 (zero in), 11 ASR by 1 (MSB replicated).
- ALU ops by op field: 00 A+B, 01 A−B, 10 A&B, 11 ~B; 16-bit wrap-around.
- FSM states and transitions:
  - WAIT: w=1; s=1 → DECODE.
  - DECODE: MOV imm → WRITE_IMM; MOV reg or MVN → GET_B; ADD/CMP/AND → GET_A; any other opcode → WAIT, no side effects.
  - WRITE_IMM: Rn ← sext(im8); → WAIT.
  - GET_A: A ← R[Rn]; → GET_B.
  - GET_B: B ← R[Rm]; → EXEC.
  - EXEC: C ← ALU(A_sel, shift(B)). A_sel is forced to 0 for MOV reg (ALU uses ADD). CMP → WAIT, all others → WRITE.
  - WRITE: Rd ← C; → WAIT.
- Latency from s sampled in WAIT to return to WAIT: MOV imm 3 cycles, MOV reg/MVN 5, ADD/AND 6, CMP 5.
- Status flags update only in CMP's EXEC cycle:
  - Z = (result==0)
  - N = result[15]
  - V = signed overflow of Rn − shift(Rm)
- Register writes, C, A and B all update on rising edge only.
- `s` held high past completion starts the next instruction immediately from WAIT.
- IR change mid-instruction affects subsequent decode and operand selection; IR must be held stable while w=0.
- Reset mid-instruction aborts: no pending write occurs and the FSM returns to WAIT.

Optional Feature:
- Macro CPU_ASR_EN.
- Defined: sh=11 performs arithmetic shift right by 1.
- Undefined: sh=11 behaves exactly as LSR (sh=10).

Decomposition:
- Package cpu_pkg: opcode and op constants, shift codes, FSM state encoding, nsel/vsel select codes.
- One natural sub-module: datapath, instance name DP.
  - Contains register file (instance REGFILE, registers R0–R7 visible hierarchically), shifter, ALU, A/B/C, status.
  - cpu retains IR, decoder and FSM.

Test Plan:
- Reset, then MOV R0,#7 (0xD007) → R0=0x0007, w returns to 1. MOV R1,#-1 (0xD1FF) → R1=0xFFFF.
- R1=1, MOV R2,R1 LSL#1 (0xC049) → R2=2. Then MOV R2,R2 LSR#1 (0xC052) → R2=1. R2=0x8000, sh=11 → 0xC000 with CPU_ASR_EN, 0x4000 without.
- R2=4, R3=1, ADD R1,R2,R3 (0xA223) → R1=5, out=5. R2=0xFFFF, R3=1 → R1=0 (wrap).
- CMP: R0=5, R1=5 (0xA801) → Z=1, N=0, V=0. R0=0x8000, R1=1 → V=1, N=0, Z=0. CMP leaves all registers unchanged.
- AND R4,R2,R1 with R2=6, R1=3 → R4=2. MVN R5,R0 with R0=7 → R5=0xFFF8. Flags unchanged by both.
- Assert reset during GET_B of an ADD → w=1 immediately, R0–R7=0, no write.
